multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ILLEGAL_HALT, default 0, meaning 0: illegal opcode returns to Fetch; 1: illegal opcode parks in Halt until reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 op  input  7  opcode of the instruction register.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  PC enable, address select (0=PC, 1=Result), data-memory write, IR enable, register-file write.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects and immediate format.
REQ-010 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 Illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-012 InstrDone  output  1  one-cycle pulse in the last state of each instruction.
REQ-013 State  output  4  current state code, for debug.

Function
REQ-014 State codes SHALL be: Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5, ExecuteR 6, ALUWB 7, ExecuteI 8, JAL 9, BEQ 10, Halt 11.
REQ-015 Transitions SHALL be:
- Fetch->Decode.
- Decode: lw(0000011)/sw(0100011)->MemAdr; R(0110011)->ExecuteR; I(0010011)->ExecuteI; jal(1101111)->JAL; beq(1100011)->BEQ; other->Fetch, or Halt if ILLEGAL_HALT=1.
- MemAdr: lw->MemRead; sw->MemWrite.
- MemRead->MemWB.
- ExecuteR, ExecuteI, JAL->ALUWB.
- MemWB, MemWrite, ALUWB, BEQ->Fetch.
- Halt->Halt.
- Unused codes 12-15->Fetch.
REQ-016 Moore outputs per state; any output not listed SHALL be 0:
- Fetch: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- Decode: ALUSrcA=01, ALUSrcB=01.
- MemAdr: ALUSrcA=10, ALUSrcB=01.
- MemRead: AdrSrc=1.
- MemWB: ResultSrc=01, RegWrite=1.
- MemWrite: AdrSrc=1, MemWrite=1.
- ExecuteR: ALUSrcA=10, ALUOp=10.
- ALUWB: RegWrite=1.
- ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-017 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinational in the same cycle.
REQ-018 ALUOp is internal, 2 bits. ALUControl SHALL decode as follows:
- 00 -> 000.
- 01 -> 001.
- 10 with funct3=000 -> 001 if op[5] AND funct7b5, else 000.
- 10 with funct3=010 -> 101.
- 10 with funct3=110 -> 011.
- 10 with funct3=111 -> 010.
- 10 with other funct3 -> 000.
- 11 -> 000.
REQ-019 ImmSrc SHALL be combinational on op: lw/I 00, sw 01, beq 10, jal 11, other 00.
REQ-020 Illegal SHALL be 1 only in Decode with an unsupported opcode.
REQ-021 InstrDone SHALL be 1 in MemWB, MemWrite, ALUWB and BEQ.
REQ-022 Instruction latencies, counted from Fetch to the next Fetch, SHALL be: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2 cycles.

Reset
REQ-023 A cycle with reset=1 at a rising edge SHALL set State to Fetch, regardless of current state, including mid-instruction and Halt.
REQ-024 While reset=1, PCWrite, IRWrite, MemWrite, RegWrite, Illegal and InstrDone SHALL be forced to 0; select outputs SHALL show Fetch values.
REQ-025 After reset deasserts, the first cycle SHALL be Fetch with IRWrite=1 and PCWrite=1.

Verification
REQ-026 Reset, then op=0000011 -> State 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 in state 4; InstrDone pulses once.
REQ-027 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in ExecuteR; with funct7b5=0 -> 000. With funct3=010/110/111 -> 101/011/010.
REQ-028 op=1100011: Zero=1 in BEQ -> PCWrite=1, ALUControl=001; Zero=0 -> PCWrite=0; next state Fetch in both cases.
REQ-029 op=0100011 -> State 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in state 5; RegWrite never 1; ImmSrc=01.
REQ-030 op=1111111: ILLEGAL_HALT=0 -> Illegal pulse in Decode, then Fetch. ILLEGAL_HALT=1 -> State stays 11 with all enables 0, and reset returns it to 0.
REQ-031 reset asserted in MemRead -> State=0 next cycle, MemWrite/RegWrite=0 throughout the reset cycle.

Source files
------------

// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Main control FSM for a multicycle RV32I-subset datapath
//             (lw, sw, R-type, I-type ALU, jal, beq). Moore state outputs
//             drive the datapath muxes and enables; ALU decoder and
//             immediate-format select are combinational.
//  Ports    : clk, reset (sync, active-high)
//             op[6:0], funct3[2:0], funct7b5, Zero          - decode inputs
//             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  - enables/select
//             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc [1:0]     - mux selects
//             ALUControl[2:0], Illegal, InstrDone, State[3:0]
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int ILLEGAL_HALT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic       InstrDone,
    output logic [3:0] State
);

    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_JAL = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_out_state;
    logic       w_supported;
    logic       w_pc_update;
    logic       w_branch;
    logic [1:0] w_aluop;

    assign w_supported = (op == c_OP_LW) || (op == c_OP_SW) || (op == c_OP_R) ||
                         (op == c_OP_I)  || (op == c_OP_JAL) || (op == c_OP_BEQ);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; codes 12-15 fall through to Fetch via default
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                if ((op == c_OP_LW) || (op == c_OP_SW)) w_next = S_MEMADR;
                else if (op == c_OP_R)                  w_next = S_EXECR;
                else if (op == c_OP_I)                  w_next = S_EXECI;
                else if (op == c_OP_JAL)                w_next = S_JAL;
                else if (op == c_OP_BEQ)                w_next = S_BEQ;
                else if (ILLEGAL_HALT != 0)             w_next = S_HALT;
                else                                    w_next = S_FETCH;
            end
            S_MEMADR:   w_next = (op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    // While reset is held the selects present Fetch values regardless of the
    // register contents, and every enable is gated off below.
    assign w_out_state = reset ? S_FETCH : r_state;

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_aluop     = 2'b00;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (w_out_state)
            S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                w_aluop = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_aluop = 2'b10;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_aluop  = 2'b01;
                w_branch = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            IRWrite     = 1'b0;
            w_pc_update = 1'b0;
        end
    end

    assign PCWrite = w_pc_update | (w_branch & Zero);

    // ALU decoder; subtract for R-type only (op[5] distinguishes R from I)
    always_comb begin
        ALUControl = 3'b000;
        case (w_aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        if (op == c_OP_SW)       ImmSrc = 2'b01;
        else if (op == c_OP_BEQ) ImmSrc = 2'b10;
        else if (op == c_OP_JAL) ImmSrc = 2'b11;
    end

    assign Illegal   = ~reset & (r_state == S_DECODE) & ~w_supported;
    assign InstrDone = ~reset & ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                                 (r_state == S_ALUWB) || (r_state == S_BEQ));
    assign State     = r_state;

endmodule
`default_nettype wire
